sel_rr_n_1: RTL and testbench

SEL_RR_N_1 -- requirements
Module: sel_rr_n_1

---
 rtl/sel_rr_n_1.sv | 83 ++++++++
 tb/tb_sel_rr_n_1.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sel_rr_n_1.sv
// N:1 channel selector with manual or round-robin grant
// feeding a one-entry registered output stage.
module sel_rr_n_1 #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                MODE,
    input  logic [SELW-1:0]     SEL,
    input  logic [CH*WIDTH-1:0] IN_DATA,
    input  logic [CH-1:0]       IN_VALID,
    output logic [CH-1:0]       IN_READY,
    output logic [WIDTH-1:0]    OUT_DATA,
    output logic [SELW-1:0]     OUT_CH,
    output logic                OUT_VALID,
    input  logic                OUT_READY
);

    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  ch_q;
    logic             valid_q;
    logic [SELW-1:0]  ptr_q;

    logic             ld;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  idx;

    assign ld = !valid_q || OUT_READY;

    // Round-robin search starts at ptr_q; index wraps since CH is 2^SELW.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        if (!MODE) begin
            gnt     = SEL;
            gnt_vld = IN_VALID[SEL];
        end else begin
            for (int k = 0; k < CH; k++) begin
                idx = ptr_q + SELW'(k);
                if (!gnt_vld && IN_VALID[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        IN_READY = '0;
        if (RST_N && ld && gnt_vld) begin
            IN_READY[gnt] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (ld) begin
            if (gnt_vld) begin
                data_q  <= IN_DATA[gnt*WIDTH +: WIDTH];
                ch_q    <= gnt;
                valid_q <= 1'b1;
                if (MODE) begin
                    ptr_q <= gnt + SELW'(1);
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign OUT_DATA  = data_q;
    assign OUT_CH    = ch_q;
    assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_sel_rr_n_1.sv
// Directed bench for sel_rr_n_1 with a cycle-level
// reference model and hand-computed literal checks.
`timescale 1ns/1ps
module tb_sel_rr_n_1;

    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    sel_rr_n_1 #(.WIDTH(W), .CH(CH)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .MODE     (mode),
        .SEL      (sel),
        .IN_DATA  (in_data),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .OUT_DATA (out_data),
        .OUT_CH   (out_ch),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic m, input int s,
                                       input logic [CH-1:0] v, input int p);
        if (!m) return v[s] ? s : -1;
        for (int k = 0; k < CH; k++) begin
            if (v[(p + k) % CH]) return (p + k) % CH;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] chan(input logic [CH*W-1:0] d, input int c);
        return d[c*W +: W];
    endfunction

    function automatic logic [CH-1:0] exp_ready();
        int g;
        logic ld;
        logic [CH-1:0] r;
        r  = '0;
        ld = !m_valid || out_ready;
        g  = model_grant(mode, int'(sel), in_valid, m_ptr);
        if (rst_n && ld && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (!m_valid || out_ready) begin
            g = model_grant(mode, int'(sel), in_valid, m_ptr);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = chan(in_data, g);
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % CH;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", 32'(out_valid), 32'(m_valid));
        chk("cyc_data",  32'(out_data),  32'(m_data));
        chk("cyc_ch",    32'(out_ch),    32'(m_ch));
        chk("cyc_ready", 32'(in_ready),  32'(exp_ready()));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = {8'hD3, 8'hA5, 8'h5A, 8'h0F};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        rst_n = 1'b1;

        // Manual select of channel 2
        sel = 2'd2;
        #1 chk("man_ready", 32'(in_ready), 32'b0100);
        step();
        chk("man_data",  32'(out_data), 32'hA5);
        chk("man_ch",    32'(out_ch), 32'd2);
        chk("man_valid", 32'(out_valid), 32'd1);

        // Round-robin fairness, all valid
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq", 32'(out_ch), 32'(i % CH));
            chk("rr_nobub", 32'(out_valid), 32'd1);
        end

        // Move pointer to 3, then sparse wrap to ch1
        in_valid = 4'b0100;
        step();
        chk("ptr3_ch", 32'(out_ch), 32'd2);
        in_valid = 4'b0010;
        #1 chk("wrap_ready", 32'(in_ready), 32'b0010);
        step();
        chk("wrap_ch", 32'(out_ch), 32'd1);
        in_valid = 4'b0000;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_ch", 32'(out_ch), 32'd1);
        in_valid = 4'b1111;
        #1 chk("ptr2_ready", 32'(in_ready), 32'b0100);
        step();
        chk("ptr2_ch", 32'(out_ch), 32'd2);

        // Backpressure with held 3C
        in_data  = {8'h3C, 8'hA5, 8'h5A, 8'h0F};
        in_valid = 4'b1000;
        step();
        chk("bp_load", 32'(out_data), 32'h3C);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_data", 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_ready", 32'(in_ready), 32'b0001);
        step();
        chk("bp_next_ch", 32'(out_ch), 32'd0);
        chk("bp_next_data", 32'(out_data), 32'h0F);

        // Mode switch while stalled
        in_valid = 4'b0001;
        step();
        chk("ms_ch0", 32'(out_ch), 32'd0);
        out_ready = 1'b0;
        mode      = 1'b0;
        sel       = 2'd3;
        in_valid  = 4'b1111;
        step();
        step();
        chk("ms_hold_ch", 32'(out_ch), 32'd0);
        chk("ms_hold_v", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1 chk("ms_ready", 32'(in_ready), 32'b1000);
        step();
        chk("ms_ch3", 32'(out_ch), 32'd3);
        chk("ms_data3", 32'(out_data), 32'h3C);
        mode = 1'b1;
        #1 chk("ms_ptr_kept", 32'(in_ready), 32'b0010);
        step();
        chk("ms_ch1", 32'(out_ch), 32'd1);

        // Async reset while full
        out_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        chk("ar_ch", 32'(out_ch), 32'd0);
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1 chk("ar_post_ready", 32'(in_ready), 32'b1000);
        step();
        chk("ar_post_ch", 32'(out_ch), 32'd3);
        chk("ar_post_valid", 32'(out_valid), 32'd1);

        // A few more mixed cycles for the model
        in_valid = 4'b0101;
        step();
        step();
        mode = 1'b0;
        sel  = 2'd1;
        step();
        in_valid = 4'b0000;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
